// File: rtl/btn_debounce_bank_pkg.sv
// Shared constants and helpers for the button debouncer bank.
// Default timing assumes a 50 MHz clk_i.
package btn_debounce_bank_pkg;

    localparam int unsigned DEF_STABLE_CYCLES = 131072;   // ~2.6 ms
    localparam int unsigned DEF_REPEAT_DELAY  = 25000000; // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD = 5000000;  // 100 ms

    // Number of bits needed to hold max_val (at least 1).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'(1) << w) <= 64'(max_val))) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_bank_channel.sv
// One debounced input: 2-flop synchroniser, stability counter, level and
// registered press/release strobes.
// Build option: DEBOUNCE_AUTOREPEAT_EN adds a per-channel repeat timer that
// re-issues press strobes while the input stays pressed.
module debounce_channel
    import btn_debounce_bank_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b1
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned      CNT_W    = cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = cnt_w(RPT_MAX);

    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    // Synchronised input after normalisation, 1 = pressed.
    assign s = sync_q[1];

    // Next-state: sync shift, stability count, level flip and strobes.
    always_comb begin
        sync_d    = {sync_q[0], btn_i ^ ACTIVE_LOW};
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = ~level_q;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

`ifdef DEBOUNCE_AUTOREPEAT_EN
        // Down-counter reloaded on acceptance; a release wins over a repeat
        // on the same edge, so press and release never coincide.
        rpt_d = rpt_q;
        if (level_d && !level_q) begin
            rpt_d = RPT_W'(REPEAT_DELAY - 1);
        end else if (level_d && level_q) begin
            if (rpt_q == '0) begin
                press_d = 1'b1;
                rpt_d   = RPT_W'(REPEAT_PERIOD - 1);
            end else begin
                rpt_d = rpt_q - RPT_W'(1);
            end
        end else begin
            rpt_d = '0;
        end
`endif
    end

    // State and output registers; reset drops any pending change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Auto-repeat timer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of CHANNELS independent button debouncers sitting behind board pins.
// Build option: DEBOUNCE_AUTOREPEAT_EN enables auto-repeat press strobes
// (REPEAT_DELAY / REPEAT_PERIOD exist only in that build).
module btn_debounce_bank
    import btn_debounce_bank_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b1
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef DEBOUNCE_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .btn_i     (btn_i[g]),
            .level_o   (level_o[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g])
        );
    end

endmodule
